// File: rtl/mm_pkg.sv
// Shared types and defaults for the matrix operand sequencer.
package mm_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;
  localparam int IDX_W = $clog2(N_DEF);

  localparam logic MAT_A = 1'b0;
  localparam logic MAT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/matrix_regfile.sv
// Storage for both operand matrices: one write port, two asynchronous read
// ports returning A[a_row][a_col] and B[b_row][b_col].
module matrix_regfile
  import mm_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic                       wsel,
  input  logic [2*$clog2(N)-1:0]     waddr,
  input  logic [W-1:0]               wdata,
  input  logic [$clog2(N)-1:0]       a_row,
  input  logic [$clog2(N)-1:0]       a_col,
  output logic [W-1:0]               a_data,
  input  logic [$clog2(N)-1:0]       b_row,
  input  logic [$clog2(N)-1:0]       b_col,
  output logic [W-1:0]               b_data
);

  logic [W-1:0] mat_q [2][N*N];

  // Matrix array: cleared on reset, one element written per enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < N*N; i++) begin
          mat_q[m][i] <= '0;
        end
      end
    end else if (we) begin
      mat_q[wsel][waddr] <= wdata;
    end
  end

  assign a_data = mat_q[MAT_A][{a_row, a_col}];
  assign b_data = mat_q[MAT_B][{b_row, b_col}];

endmodule

// File: rtl/matrix_operand_sequencer.sv
// Streams (A[r][k], B[k][c]) pairs in r/c/k order to the GF(2^8) multiplier,
// with valid/ready flow control and per-dot-product first/last markers.
//
// state  | meaning
// IDLE   | loads accepted, waiting for start
// STREAM | presenting pairs, advancing on each transfer
// DONE   | one-cycle done pulse after the final transfer
module matrix_operand_sequencer
  import mm_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_en,
  input  logic                    ld_sel,
  input  logic [2*$clog2(N)-1:0]  ld_addr,
  input  logic [W-1:0]            ld_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [W-1:0]            mc,
  output logic [W-1:0]            mi,
  output logic                    op_valid,
  input  logic                    op_ready,
  output logic                    op_first,
  output logic                    op_last,
  output logic [$clog2(N)-1:0]    op_row,
  output logic [$clog2(N)-1:0]    op_col
);

  localparam int IW = $clog2(N);

  state_e          state_q, state_d;
  logic [IW-1:0]   r_q, c_q, k_q, r_d, c_d, k_d;
  logic [W-1:0]    mc_q, mc_d, mi_q, mi_d;
  logic            first_q, first_d, last_q, last_d;

  logic            we, xfer, last_pair;
  logic [3*IW-1:0] idx_inc;
  logic [IW-1:0]   rd_r, rd_c, rd_k;
  logic [W-1:0]    rd_a, rd_b, a_fwd, b_fwd;

  assign we        = ld_en && (state_q == IDLE);
  assign xfer      = (state_q == STREAM) && op_ready;
  assign last_pair = &{r_q, c_q, k_q};
  // One flat counter: k wrap carries into c, c wrap carries into r.
  assign idx_inc   = {r_q, c_q, k_q} + {{(3*IW-1){1'b0}}, 1'b1};

  // Address of the pair to load next: the first pair on start, else the successor.
  assign {rd_r, rd_c, rd_k} = (state_q == STREAM) ? idx_inc : '0;

  matrix_regfile #(.N(N), .W(W)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .wsel   (ld_sel),
    .waddr  (ld_addr),
    .wdata  (ld_data),
    .a_row  (rd_r),
    .a_col  (rd_k),
    .a_data (rd_a),
    .b_row  (rd_k),
    .b_col  (rd_c),
    .b_data (rd_b)
  );

  // A write coinciding with start must already show in the first pair.
  assign a_fwd = (we && ld_sel == MAT_A && ld_addr == {rd_r, rd_k}) ? ld_data : rd_a;
  assign b_fwd = (we && ld_sel == MAT_B && ld_addr == {rd_k, rd_c}) ? ld_data : rd_b;

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      mc_q    <= '0;
      mi_q    <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      mc_q    <= mc_d;
      mi_q    <= mi_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  // Next state, counter advance and next output values.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    mc_d    = mc_q;
    mi_d    = mi_q;
    first_d = first_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          mc_d    = a_fwd;
          mi_d    = b_fwd;
          first_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (last_pair) begin
            state_d = DONE;
            r_d     = '0;
            c_d     = '0;
            k_d     = '0;
            first_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            r_d     = rd_r;
            c_d     = rd_c;
            k_d     = rd_k;
            mc_d    = a_fwd;
            mi_d    = b_fwd;
            first_d = (rd_k == '0);
            last_d  = &rd_k;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == STREAM);
  assign op_valid = (state_q == STREAM);
  assign done     = (state_q == DONE);
  assign mc       = mc_q;
  assign mi       = mi_q;
  assign op_first = first_q;
  assign op_last  = last_q;
  assign op_row   = r_q;
  assign op_col   = c_q;

endmodule

// File: tb/tb_matrix_operand_sequencer.sv
// Bench for matrix_operand_sequencer: matrices kept as plain arrays, the
// expected pair for stream position p is A[p/N^2][p%N] and B[p%N][(p/N)%N].
module tb_matrix_operand_sequencer;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam int NP = N * N * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_en, ld_sel, start, op_ready;
  logic [2*IW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic          busy, done, op_valid, op_first, op_last;
  logic [W-1:0]  mc, mi;
  logic [IW-1:0] op_row, op_col;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] ma [N][N];
  logic [W-1:0] mb [N][N];

  int aes_a [N][N] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
  int aes_b [N][N] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};

  matrix_operand_sequencer #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_en    (ld_en),
    .ld_sel   (ld_sel),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .mc       (mc),
    .mi       (mi),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_first (op_first),
    .op_last  (op_last),
    .op_row   (op_row),
    .op_col   (op_col)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
  endtask

  task automatic load(input logic sel, input int row, input int col, input logic [W-1:0] d);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_addr = {row[IW-1:0], col[IW-1:0]};
    ld_data = d;
    step();
    ld_en = 1'b0;
    if (sel) mb[row][col] = d;
    else     ma[row][col] = d;
  endtask

  task automatic load_aes();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        load(1'b0, r, c, W'(aes_a[r][c]));
        load(1'b1, r, c, W'(aes_b[r][c]));
      end
  endtask

  // Runs one full stream and checks every presented pair, the done pulse and
  // its latency from the start edge.
  task automatic run_stream(input bit rand_ready, input int stall_pair, input int stall_len,
                            input int restart_pair, input int load_pair,
                            input bit with_load, input logic [W-1:0] wl_data);
    int pair = 0, cyc = 0, stalled = 0, stalls = 0;
    bit finished = 0, restarted = 0, loaded = 0, rdy;
    int er, ec, ek;
    start = 1'b1;
    op_ready = 1'b1;
    if (with_load) begin
      ld_en = 1'b1; ld_sel = 1'b1; ld_addr = '0; ld_data = wl_data;
      mb[0][0] = wl_data;
    end
    step();
    start = 1'b0;
    ld_en = 1'b0;
    cyc = 1;
    while (!finished && cyc < 3000) begin
      if (op_valid) begin
        er = pair / (N * N); ec = (pair / N) % N; ek = pair % N;
        checks++;
        if (pair >= NP) begin
          errors++;
          $display("FAIL extra_pair: pair index %0d, required below %0d", pair, NP);
        end else begin
          if (mc !== ma[er][ek] || mi !== mb[ek][ec]) begin
            errors++;
            $display("FAIL pair_data[%0d]: got (%0h,%0h) required (%0h,%0h)",
                     pair, mc, mi, ma[er][ek], mb[ek][ec]);
          end
          checks++;
          if (op_first !== (ek == 0) || op_last !== (ek == N - 1) ||
              op_row !== IW'(er) || op_col !== IW'(ec)) begin
            errors++;
            $display("FAIL pair_tags[%0d]: got first=%b last=%b row=%0d col=%0d required %b %b %0d %0d",
                     pair, op_first, op_last, op_row, op_col, ek == 0, ek == N - 1, er, ec);
          end
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL stream_flags[%0d]: got busy=%b done=%b required 1 0", pair, busy, done);
        end
        if (pair == stall_pair && stalled < stall_len) begin
          rdy = 1'b0;
          stalled++;
        end else if (rand_ready) rdy = ($urandom_range(0, 2) != 0);
        else rdy = 1'b1;
        op_ready = rdy;
        if (pair == restart_pair && !restarted) begin start = 1'b1; restarted = 1; end
        if (pair == load_pair && !loaded) begin
          ld_en = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = 8'hFF; loaded = 1;
        end
        step();
        start = 1'b0;
        ld_en = 1'b0;
        cyc++;
        if (rdy) pair++;
        else stalls++;
      end else begin
        finished = 1;
        checks++;
        if (done !== 1'b1 || pair !== NP) begin
          errors++;
          $display("FAIL stream_end: got done=%b transfers=%0d required 1 %0d", done, pair, NP);
        end
        checks++;
        if (cyc !== NP + 1 + stalls) begin
          errors++;
          $display("FAIL done_latency: got %0d cycles required %0d", cyc, NP + 1 + stalls);
        end
      end
    end
    op_ready = 1'b1;
    if (!finished) begin
      checks++; errors++;
      $display("FAIL stream_timeout: transfers %0d after %0d cycles", pair, cyc);
    end
    step();
    checks++;
    if (done !== 1'b0 || op_valid !== 1'b0 || busy !== 1'b0 ||
        mc !== ma[N-1][N-1] || mi !== mb[N-1][N-1]) begin
      errors++;
      $display("FAIL after_done: got done=%b valid=%b busy=%b mc=%0h mi=%0h required 0 0 0 %0h %0h",
               done, op_valid, busy, mc, mi, ma[N-1][N-1], mb[N-1][N-1]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_en = 0; ld_sel = 0; ld_addr = '0; ld_data = '0; start = 0; op_ready = 1;
    clear_model();
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if ({busy, done, op_valid, op_first, op_last} !== 5'b0 || mc !== '0 || mi !== '0 ||
        op_row !== '0 || op_col !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got flags=%b mc=%0h mi=%0h row=%0d col=%0d required all zero",
               {busy, done, op_valid, op_first, op_last}, mc, mi, op_row, op_col);
    end
  endtask

  task automatic test_aes_stream();
    load_aes();
    run_stream(0, -1, 0, -1, -1, 0, '0);
  endtask

  task automatic test_back_pressure();
    run_stream(0, 5, 3, -1, -1, 0, '0);
  endtask

  task automatic test_ignored_controls();
    run_stream(0, -1, 0, 10, 20, 0, '0);
  endtask

  task automatic test_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        load(1'b0, r, c, W'($urandom));
        load(1'b1, r, c, W'($urandom));
      end
    run_stream(1, -1, 0, -1, -1, 0, '0);
  endtask

  task automatic test_abort();
    int pair = 0;
    load_aes();
    start = 1'b1;
    step();
    start = 1'b0;
    while (pair < 30) begin
      step();
      pair++;
    end
    checks++;
    if (op_valid !== 1'b1 || mc !== ma[1][2] || mi !== mb[2][3]) begin
      errors++;
      $display("FAIL pre_abort_pair30: got valid=%b (%0h,%0h) required 1 (%0h,%0h)",
               op_valid, mc, mi, ma[1][2], mb[2][3]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (op_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mc !== '0 || mi !== '0) begin
      errors++;
      $display("FAIL abort_async: got valid=%b busy=%b done=%b mc=%0h mi=%0h required 0 0 0 0 0",
               op_valid, busy, done, mc, mi);
    end
    step();
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (op_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle: got valid=%b done=%b busy=%b required 0 0 0", op_valid, done, busy);
      end
    end
    run_stream(0, -1, 0, -1, -1, 0, '0);
  endtask

  task automatic test_same_cycle_load();
    load_aes();
    run_stream(0, -1, 0, -1, -1, 1, 8'h55);
  endtask

  initial begin
    test_reset();
    test_aes_stream();
    test_back_pressure();
    test_ignored_controls();
    test_random();
    test_abort();
    test_same_cycle_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
